// File: rtl/aes_text_out_serializer.sv
// Output-side unloader for the AES core. It captures finished text_out blocks
// into a 2-deep block FIFO and streams each block MSW-first over valid/ready.
module aes_text_out_serializer #(
  parameter int unsigned BLK_W  = 128,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [BLK_W-1:0]  text_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              full,
  output logic              overflow
);

  localparam int unsigned NW    = BLK_W / WORD_W;
  localparam int unsigned IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NW - 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   a_q, a_d;
  logic [BLK_W-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               out_valid_q, out_valid_d;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;
  logic               hs;
  logic               fin;

  // State and registered outputs; reset drops all buffered blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

  // Occupancy transitions, beat index and next-cycle output values.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    out_data_d  = '0;
    out_last_d  = 1'b0;
    full_d      = 1'b0;

    hs  = out_valid_q & out_ready;
    fin = hs & out_last_q;

    if (hs) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (done) begin
          a_d     = text_out;
          idx_d   = '0;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (fin && done) begin
          a_d   = text_out;
          idx_d = '0;
        end else if (fin) begin
          state_d = ST_EMPTY;
        end else if (done) begin
          b_d     = text_out;
          state_d = ST_TWO;
        end
      end
      ST_TWO: begin
        if (fin) begin
          // The head slot frees this cycle, so a concurrent done still fits.
          a_d   = b_q;
          idx_d = '0;
          if (done) begin
            b_d = text_out;
          end else begin
            state_d = ST_ONE;
          end
        end else if (done) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    out_valid_d = (state_d != ST_EMPTY);
    full_d      = (state_d == ST_TWO);
    out_last_d  = out_valid_d & (idx_d == IDX_LAST);
    if (out_valid_d) begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (idx_d == IDX_W'(i)) begin
          out_data_d = a_d[BLK_W-1-i*WORD_W -: WORD_W];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign full      = full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_aes_text_out_serializer.sv
// Self-checking bench for aes_text_out_serializer: directed scenarios plus
// random traffic, compared each cycle against a queue-based block model.
module tb_aes_text_out_serializer;

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned NW     = BLK_W / WORD_W;

  logic              clk;
  logic              rst;
  logic              done;
  logic [BLK_W-1:0]  text_out;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              full;
  logic              overflow;

  int n_total;
  int n_bad;

  // Model state: pending blocks, beat index into the head, sticky overflow.
  logic [BLK_W-1:0] m_q[$];
  int               m_idx;
  logic             m_ovf;

  aes_text_out_serializer #(.BLK_W(BLK_W), .WORD_W(WORD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .text_out  (text_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [BLK_W-1:0] got,
                          input logic [BLK_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] model_word();
    logic [BLK_W-1:0] blk;
    blk = m_q[0];
    return WORD_W'(blk >> ((NW - 1 - m_idx) * WORD_W));
  endfunction

  // One clock: drive inputs, compare outputs against the model, then advance.
  task automatic step(input logic d, input logic [BLK_W-1:0] t,
                      input logic r, input logic rs);
    logic mv;
    done      = d;
    text_out  = t;
    out_ready = r;
    rst       = rs;
    mv = (m_q.size() != 0);
    check_eq("out_valid", BLK_W'(out_valid), BLK_W'(mv));
    check_eq("out_last", BLK_W'(out_last), BLK_W'(mv && m_idx == NW - 1));
    check_eq("full", BLK_W'(full), BLK_W'(m_q.size() == 2));
    check_eq("overflow", BLK_W'(overflow), BLK_W'(m_ovf));
    if (mv) check_eq("out_data", BLK_W'(out_data), BLK_W'(model_word()));
    @(posedge clk);
    if (rs) begin
      m_q.delete();
      m_idx = 0;
      m_ovf = 1'b0;
    end else begin
      if (mv && r) begin
        if (m_idx == NW - 1) begin
          void'(m_q.pop_front());
          m_idx = 0;
        end else begin
          m_idx++;
        end
      end
      if (d) begin
        if (m_q.size() < 2) m_q.push_back(t);
        else m_ovf = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [BLK_W-1:0] rnd_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [BLK_W-1:0] blk_k;
    logic [BLK_W-1:0] blk_x;
    logic [BLK_W-1:0] blk_y;
    logic [BLK_W-1:0] blk_z;
    logic [6:0]       bp;
    n_total = 0;
    n_bad   = 0;
    m_idx   = 0;
    m_ovf   = 1'b0;
    blk_k = 128'h00112233_44556677_8899aabb_ccddeeff;

    done = 1'b0; text_out = '0; out_ready = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data", BLK_W'(out_data), '0);

    // Single block, sink always ready; first word explicitly pinned.
    step(1'b1, blk_k, 1'b1, 1'b0);
    check_eq("first_word", BLK_W'(out_data), BLK_W'(32'h00112233));
    repeat (5) step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure pattern on the same block.
    bp = 7'b1101001;
    step(1'b1, blk_k, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, bp[i], 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // Two blocks two cycles apart, no bubble.
    blk_x = rnd_blk();
    blk_y = rnd_blk();
    step(1'b1, blk_x, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, blk_y, 1'b1, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1, 1'b0);

    // Overflow: three consecutive dones while stalled.
    step(1'b1, rnd_blk(), 1'b0, 1'b0);
    step(1'b1, rnd_blk(), 1'b0, 1'b0);
    step(1'b1, rnd_blk(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_eq("ovf_set", BLK_W'(overflow), BLK_W'(1'b1));
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);

    // Reset clears overflow; then done coinciding with final handshake in TWO.
    step(1'b0, '0, 1'b0, 1'b1);
    blk_z = rnd_blk();
    step(1'b1, rnd_blk(), 1'b0, 1'b0);
    step(1'b1, rnd_blk(), 1'b0, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, blk_z, 1'b1, 1'b0);
    check_eq("simul_full", BLK_W'(full), BLK_W'(1'b1));
    check_eq("simul_ovf", BLK_W'(overflow), BLK_W'(1'b0));
    repeat (9) step(1'b0, '0, 1'b1, 1'b0);

    // Reset after two words, then a fresh block with latency 1.
    step(1'b1, rnd_blk(), 1'b1, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, blk_k, 1'b1, 1'b0);
    check_eq("post_rst_word0", BLK_W'(out_data), BLK_W'(32'h00112233));
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      step(($urandom_range(0, 3) == 0), rnd_blk(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 199) == 0));
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
